// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Control sequencer for the SAP-1.5 bus datapath. A step counter walks each
//   instruction through fetch (T0, T1) and one to three execute steps (T2-T4);
//   the control word is decoded combinationally from the step, the IR opcode
//   nibble and, for conditional jumps, the registered flags. HLT latches a
//   halted state that only reset clears.
//
// Ports
//   clk           in   system clock, rising-edge
//   reset         in   synchronous, active-high
//   opcode        in   IR[7:4], meaningful from T2 onward
//   flag_zero     in   registered Z flag
//   flag_carry    in   registered C flag
//   control_word  out  16 datapath enables (bit map in the localparams below)
//   step          out  current microstep, 0..4
//   halted        out  high once HLT has executed
module microcode_sequencer #(
   parameter int OPCODE_W = 4,
   parameter int STEP_W   = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                flag_zero,
   input  logic                flag_carry,
   output logic [15:0]         control_word,
   output logic [STEP_W-1:0]   step,
   output logic                halted
);

   // Control word bits
   localparam logic [15:0] PC_INC     = 16'h0001;
   localparam logic [15:0] PC_LOAD    = 16'h0002;
   localparam logic [15:0] PC_OE      = 16'h0004;
   localparam logic [15:0] MAR_LOAD   = 16'h0008;
   localparam logic [15:0] RAM_WE     = 16'h0010;
   localparam logic [15:0] RAM_OE     = 16'h0020;
   localparam logic [15:0] IR_LOAD    = 16'h0040;
   localparam logic [15:0] IR_OE      = 16'h0080;
   localparam logic [15:0] A_LOAD     = 16'h0100;
   localparam logic [15:0] A_OE       = 16'h0200;
   localparam logic [15:0] ALU_OE     = 16'h0400;
   localparam logic [15:0] ALU_SUB    = 16'h0800;
   localparam logic [15:0] B_LOAD     = 16'h1000;
   localparam logic [15:0] OUT_LOAD   = 16'h2000;
   localparam logic [15:0] FLAGS_LOAD = 16'h4000;
   localparam logic [15:0] HALT       = 16'h8000;

   // Microsteps
   localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
   localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
   localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
   localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
   localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

   // Opcodes
   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

   logic [STEP_W-1:0] step_q, step_d;
   logic              halted_q, halted_d;
   logic [15:0]       cw_dec;
   logic              is_last;
   logic              hlt_now;

   always_comb begin
      cw_dec  = 16'h0000;
      is_last = 1'b0;
      hlt_now = 1'b0;
      if (step_q == T0) begin
         cw_dec = PC_OE | MAR_LOAD;
      end else if (step_q == T1) begin
         cw_dec = RAM_OE | IR_LOAD | PC_INC;
      end else begin
         // Any execute step ends the instruction unless a longer opcode
         // clears this below; keeps stray steps from running past T4.
         is_last = 1'b1;
         case (opcode)
            OP_LDA, OP_STA: begin
               if (step_q == T2) begin
                  cw_dec  = IR_OE | MAR_LOAD;
                  is_last = 1'b0;
               end else if (step_q == T3) begin
                  cw_dec = (opcode == OP_LDA) ? (RAM_OE | A_LOAD) : (A_OE | RAM_WE);
               end
            end
            OP_ADD, OP_SUB: begin
               if (step_q == T2) begin
                  cw_dec  = IR_OE | MAR_LOAD;
                  is_last = 1'b0;
               end else if (step_q == T3) begin
                  cw_dec  = RAM_OE | B_LOAD;
                  is_last = 1'b0;
               end else if (step_q == T4) begin
                  cw_dec = ALU_OE | A_LOAD | FLAGS_LOAD;
               end
               if (opcode == OP_SUB && (step_q == T3 || step_q == T4)) begin
                  cw_dec = cw_dec | ALU_SUB;
               end
            end
            OP_LDI:  if (step_q == T2) cw_dec = IR_OE | A_LOAD;
            OP_JMP:  if (step_q == T2) cw_dec = IR_OE | PC_LOAD;
            // Flags only matter here, in T2 of a conditional jump.
            OP_JZ:   if (step_q == T2 && flag_zero)  cw_dec = IR_OE | PC_LOAD;
            OP_JC:   if (step_q == T2 && flag_carry) cw_dec = IR_OE | PC_LOAD;
            OP_OUT:  if (step_q == T2) cw_dec = A_OE | OUT_LOAD;
            OP_HLT: begin
               if (step_q == T2) begin
                  cw_dec  = HALT;
                  hlt_now = 1'b1;
               end
            end
            default: cw_dec = 16'h0000;
         endcase
      end
   end

   always_comb begin
      step_d   = step_q + STEP_W'(1);
      halted_d = halted_q;
      if (halted_q) begin
         step_d = step_q;
      end else if (hlt_now) begin
         // Freeze on T2 so the halted state shows the step HLT stopped in.
         step_d   = step_q;
         halted_d = 1'b1;
      end else if (is_last) begin
         step_d = T0;
      end
   end

   always_comb begin
      control_word = cw_dec;
      if (halted_q) control_word = HALT;
      if (reset)    control_word = 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: a small behavioural SAP-1.5 datapath around
// the sequencer, driven through directed programs.
module tb_microcode_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  opcode;
   logic        fz = 1'b0;
   logic        fc = 1'b0;
   logic [15:0] cw;
   logic [2:0]  step;
   logic        halted;

   always #5 clk = ~clk;

   microcode_sequencer #(.OPCODE_W(4), .STEP_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .flag_zero    (fz),
      .flag_carry   (fc),
      .control_word (cw),
      .step         (step),
      .halted       (halted)
   );

   // Behavioural datapath
   logic [7:0] prog [16];
   logic [7:0] ram  [16];
   logic [3:0] pc, mar;
   logic [7:0] ir, a, b, out_val, bus, alu;

   assign opcode = ir[7:4];

   always_comb begin
      alu = cw[11] ? (a - b) : (a + b);
      bus = 8'h00;
      if (cw[2])       bus = {4'h0, pc};
      else if (cw[5])  bus = ram[mar];
      else if (cw[7])  bus = {4'h0, ir[3:0]};
      else if (cw[9])  bus = a;
      else if (cw[10]) bus = alu;
   end

   always @(posedge clk) begin
      if (reset) begin
         pc      <= 4'h0;
         mar     <= 4'h0;
         ir      <= 8'h00;
         a       <= 8'h00;
         b       <= 8'h00;
         out_val <= 8'h00;
         for (int i = 0; i < 16; i++) ram[i] <= prog[i];
      end else begin
         if (cw[1])      pc <= bus[3:0];
         else if (cw[0]) pc <= pc + 4'h1;
         if (cw[3])  mar <= bus[3:0];
         if (cw[4])  ram[mar] <= bus;
         if (cw[6])  ir <= bus;
         if (cw[8])  a <= bus;
         if (cw[12]) b <= bus;
         if (cw[13]) out_val <= bus;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Every-cycle invariants: single bus driver, no RAM read+write, step <= 4.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         assert (($countones({cw[2], cw[5], cw[7], cw[9], cw[10]}) <= 1)
                 && !(cw[4] && cw[5]) && (step <= 3'd4)) else begin
            errors++;
            $error("FAIL invariant: observed cw=%h step=%0d expected one driver, step<=4",
                   cw, step);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic clear_prog;
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   // Returns at the negedge of the first T0 cycle after reset.
   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_cw", cw, 16'h0000);
      @(negedge clk);
      chk("rst_step", {13'h0, step}, 16'h0000);
      chk("rst_halted", {15'h0, halted}, 16'h0000);
      reset = 1'b0;
   endtask

   task automatic set_flag(input logic use_c, input logic v);
      if (use_c) fc = v;
      else       fz = v;
   endtask

   task automatic jtest(input string tag, input logic [7:0] instr, input logic use_c,
                        input logic f, input logic [3:0] exp_pc);
      clear_prog();
      prog[0] = instr;
      prog[1] = 8'hF0;
      prog[9] = 8'hF0;
      do_reset();
      set_flag(use_c, ~f);
      #1;
      chk({tag, "_t0"}, cw, 16'h000C);
      @(negedge clk);
      set_flag(use_c, f);
      #1;
      set_flag(use_c, ~f);
      #1;
      chk({tag, "_t1"}, cw, 16'h0061);
      @(negedge clk);
      set_flag(use_c, f);
      #1;
      chk({tag, "_t2"}, cw, f ? 16'h0082 : 16'h0000);
      @(negedge clk);
      set_flag(use_c, ~f);
      chk({tag, "_step"}, {13'h0, step}, 16'h0000);
      chk({tag, "_pc"}, {12'h0, pc}, {12'h0, exp_pc});
      fz = 1'b0;
      fc = 1'b0;
   endtask

   task automatic load_addsub;
      clear_prog();
      prog[0]  = 8'h1E;
      prog[1]  = 8'h2F;
      prog[2]  = 8'h3F;
      prog[3]  = 8'hE0;
      prog[4]  = 8'hF0;
      prog[14] = 8'h05;
      prog[15] = 8'h03;
   endtask

   initial begin
      int n, fl, subc, subbad, last0, seen;
      int lens[$];
      int exp_tr[7] = '{0, 1, 2, 3, 0, 1, 2};

      // LDA 15; HLT
      clear_prog();
      prog[0]  = 8'h1F;
      prog[1]  = 8'hFF;
      prog[15] = 8'hAB;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         chk("lda_trace", {13'h0, step}, exp_tr[i][15:0]);
         if (i == 2) chk("lda_t2_cw", cw, 16'h0088);
         @(negedge clk);
      end
      chk("lda_halted", {15'h0, halted}, 16'h0001);
      chk("lda_a", {8'h0, a}, 16'h00AB);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         fz = ~fz;
         fc = ~fc;
         #1;
         if (cw !== 16'h8000 || step !== 3'd2) n++;
         @(negedge clk);
      end
      chk("halt_hold_bad_cycles", n[15:0], 16'h0000);
      fz = 1'b0;
      fc = 1'b0;

      // LDA 14; ADD 15; SUB 15; OUT; HLT
      load_addsub();
      do_reset();
      n = 0; fl = 0; subc = 0; subbad = 0; last0 = 0;
      lens.delete();
      while (!halted && n < 40) begin
         if (cw[14]) fl++;
         if (cw[11]) begin
            subc++;
            if (!(opcode == 4'h3 && (step == 3'd3 || step == 3'd4))) subbad++;
         end
         if (step == 3'd0 && n > 0) begin
            lens.push_back(n - last0);
            last0 = n;
         end
         @(negedge clk);
         n++;
      end
      chk("addsub_cycles", n[15:0], 16'd20);
      chk("addsub_ninstr", lens.size(), 16'd4);
      if (lens.size() == 4) begin
         chk("lda_len", lens[0][15:0], 16'd4);
         chk("add_len", lens[1][15:0], 16'd5);
         chk("sub_len", lens[2][15:0], 16'd5);
         chk("out_len", lens[3][15:0], 16'd3);
      end
      chk("out_val", {8'h0, out_val}, 16'h0005);
      chk("flags_load_pulses", fl[15:0], 16'd2);
      chk("alu_sub_cycles", subc[15:0], 16'd2);
      chk("alu_sub_misplaced", subbad[15:0], 16'd0);

      // Conditional jumps
      jtest("jz0", 8'h79, 1'b0, 1'b0, 4'h1);
      jtest("jz1", 8'h79, 1'b0, 1'b1, 4'h9);
      jtest("jc0", 8'h89, 1'b1, 1'b0, 4'h1);
      jtest("jc1", 8'h89, 1'b1, 1'b1, 4'h9);

      // LDI 7; STA 12; HLT
      clear_prog();
      prog[0] = 8'h57;
      prog[1] = 8'h4C;
      prog[2] = 8'hF0;
      do_reset();
      n = 0; seen = 0;
      while (!halted && n < 30) begin
         if (opcode == 4'h5 && step == 3'd2) chk("ldi_t2_cw", cw, 16'h0180);
         if (opcode == 4'h4 && step == 3'd3) begin
            chk("sta_t3_cw", cw, 16'h0210);
            seen++;
         end
         @(negedge clk);
         n++;
      end
      chk("sta_cycles", n[15:0], 16'd10);
      chk("sta_seen", seen[15:0], 16'd1);
      chk("sta_ram12", {8'h0, ram[12]}, 16'h0007);

      // Reset during ADD's T3
      load_addsub();
      do_reset();
      n = 0;
      while (!(opcode == 4'h2 && step == 3'd3) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("add_t3_reached", {15'h0, (opcode == 4'h2 && step == 3'd3)}, 16'h0001);
      chk("add_t3_cw", cw, 16'h1020);
      reset = 1'b1;
      #1;
      chk("midrst_cw", cw, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_step", {13'h0, step}, 16'h0000);
      chk("midrst_halted", {15'h0, halted}, 16'h0000);
      chk("midrst_pc", {12'h0, pc}, 16'h0000);
      #1;
      chk("midrst_t0_cw", cw, 16'h000C);
      n = 0;
      while (!halted && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_cycles", n[15:0], 16'd20);
      chk("midrst_out", {8'h0, out_val}, 16'h0005);

      // Undefined opcode 0xA; LDI 3; HLT
      clear_prog();
      prog[0] = 8'hA0;
      prog[1] = 8'h53;
      prog[2] = 8'hF0;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      chk("undef_t2_step", {13'h0, step}, 16'h0002);
      chk("undef_t2_cw", cw, 16'h0000);
      @(negedge clk);
      chk("undef_next_step", {13'h0, step}, 16'h0000);
      chk("undef_next_pc", {12'h0, pc}, 16'h0001);
      n = 0;
      while (!halted && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("undef_halted", {15'h0, halted}, 16'h0001);
      chk("undef_a", {8'h0, a}, 16'h0003);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
